motion_seg_seq: RTL
===================

MOTION_SEG_SEQ -- requirements
Module: motion_seg_seq

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, giving the segment queue depth; it SHALL be a power of two, minimum 2.
REQ-002 The block SHALL have parameter DIR_SETUP, default 100, giving the direction-settle dwell in clk cycles (2 us at 50 MHz); minimum 1.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock (50 MHz).
REQ-004 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port cmd_valid, input, 1 bit: segment command offered.
REQ-006 The block SHALL have port cmd_ready, output, 1 bit: queue can accept a segment.
REQ-007 The block SHALL have port cmd_period, input, 32 bits: step period for the segment, in clk cycles.
REQ-008 The block SHALL have port cmd_steps, input, 24 bits: step count for the segment.
REQ-009 The block SHALL have port cmd_dir, input, 1 bit: direction for the segment.
REQ-010 The block SHALL have port run_en, input, 1 bit: permits segments to start.
REQ-011 The block SHALL have port abort, input, 1 bit: immediate stop and flush.
REQ-012 The block SHALL have port step_pulse, input, 1 bit: one-cycle pulse per step issued by the driven step generator.
REQ-013 The block SHALL have port sg_period, output, 32 bits: period presented to the step generator.
REQ-014 The block SHALL have port sg_dir, output, 1 bit: direction presented to the step generator.
REQ-015 The block SHALL have port sg_en, output, 1 bit: step generator enable.
REQ-016 The block SHALL have port steps_left, output, 24 bits: steps remaining in the active segment.
REQ-017 The block SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1 bits: number of queued segments.
REQ-018 The block SHALL have port seg_done, output, 1 bit: one-cycle pulse when a segment completes.
REQ-019 The block SHALL have port pos, output, 32 bits, signed: step position counter (see Configuration).

Function
REQ-020 A command SHALL be accepted on a cycle where cmd_valid and cmd_ready are both high; cmd_ready SHALL equal (fifo_level != FIFO_DEPTH) and SHALL NOT depend on cmd_valid.
REQ-021 fifo_level SHALL update on the cycle after a push or pop; a simultaneous push and pop SHALL leave it unchanged; the queue SHALL be first-in first-out.
REQ-022 The FSM SHALL have the states IDLE, LOAD, SETTLE and RUN; all outputs SHALL be registered.
REQ-023 IDLE: sg_en SHALL be 0; if run_en is high and fifo_level is nonzero, the FSM SHALL move to LOAD. A command accepted on cycle N SHALL therefore give LOAD at N+2.
REQ-024 LOAD SHALL pop the queue head and take one of these actions:
- steps == 0: discard the segment and stay in LOAD if further segments are queued, else go to IDLE.
- dir differs from the current sg_dir: update sg_dir, load sg_period and steps_left, go to SETTLE.
- otherwise: load sg_period and steps_left, go to RUN.
REQ-025 SETTLE: sg_en SHALL be 0 for exactly DIR_SETUP cycles, then the FSM SHALL go to RUN.
REQ-026 RUN: sg_en SHALL be 1; each step_pulse SHALL decrement steps_left by 1.
REQ-027 In RUN, the step_pulse that takes steps_left from 1 to 0 SHALL pulse seg_done on the next cycle, and the FSM SHALL then take the first matching action:
- run_en high, head queued, head steps nonzero, head dir equal to sg_dir: pop and load in the same cycle, stay in RUN, keep sg_en high (seamless hand-off).
- a segment is queued and run_en is high: go to LOAD with sg_en low.
- otherwise: go to IDLE.
REQ-028 Deasserting run_en during RUN SHALL let the active segment finish and SHALL start no new segment.
REQ-029 step_pulse SHALL be ignored in IDLE, LOAD and SETTLE.
REQ-030 abort SHALL take priority over everything, in any state. On the next cycle it SHALL force: state IDLE, sg_en 0, steps_left 0, queue flushed (fifo_level 0), and no push that cycle. sg_period, sg_dir and pos SHALL be retained.
REQ-031 sg_period SHALL hold its last value while in IDLE.

Reset
REQ-032 While reset_n is low, the following SHALL be held at the values given:
- state IDLE.
- sg_en, sg_dir, sg_period, steps_left, fifo_level, seg_done and pos all 0.
- cmd_ready 1 once reset_n is high.
REQ-033 Release of reset SHALL be synchronous to clk.
REQ-034 Asserting reset mid-segment SHALL drop sg_en immediately, without waiting for a clk edge.

Configuration
REQ-035 With MOTION_SEG_SEQ_POS_EN defined, pos SHALL change on every step_pulse accepted in RUN: +1 when sg_dir is 1, -1 when sg_dir is 0, wrapping modulo 2^32. It SHALL be cleared only by reset.
REQ-036 Without MOTION_SEG_SEQ_POS_EN, pos SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-037 Reset: hold reset_n low for 5 cycles, then release -> sg_en=0, fifo_level=0, cmd_ready=1, pos=0.
REQ-038 Single segment: push (period=10, steps=3, dir=0) on cycle N with run_en=1 -> RUN and sg_en=1 at N+3, sg_period=10. After 3 step_pulses -> seg_done pulses once, sg_en=0 the following cycle.
REQ-039 Seamless hand-off: queue (10,3,0) then (20,2,0) -> sg_en never drops; sg_period changes 10->20 on the cycle after the 3rd step_pulse; 5 step_pulses total give 2 seg_done pulses.
REQ-040 Direction change with DIR_SETUP=4: queue (10,2,0) then (10,2,1) -> sg_en is low for LOAD plus exactly 4 SETTLE cycles; sg_dir goes to 1 on SETTLE entry. With MOTION_SEG_SEQ_POS_EN defined, pos=0 at the end.
REQ-041 Full and abort: with run_en=0, push 9 commands -> 8 accepted, cmd_ready=0, fifo_level=8. Then set run_en=1 and assert abort mid-RUN -> next cycle sg_en=0, fifo_level=0, steps_left=0.

Source files
------------

// File: rtl/motion_seg_seq.sv
// motion_seg_seq: queues motion segments and sequences them onto a step generator (period, dir, enable).
// Latency: command accepted on cycle N reaches LOAD at N+2 and RUN (sg_en high) at N+3; a direction flip adds DIR_SETUP settle cycles.
// Backpressure: cmd_ready drops while the FIFO_DEPTH-entry segment queue is full; abort flushes the queue and blocks that cycle's push.
// Build option: define MOTION_SEG_SEQ_POS_EN to add the signed step position counter on pos (otherwise pos is tied to 0).

// Generic segment store with occupancy count and synchronous flush; head word is read combinationally.
module motion_seg_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_dat,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LEVEL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && (level != LEVEL_FULL);
    assign do_pop   = pop && (level != '0);
    assign head_dat = mem[rd_ptr];

    // storage array: written on an accepted push, contents need no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // pointers and occupancy; flush empties the queue in one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LEVEL_ONE;
                2'b01:   level <= level - LEVEL_ONE;
                default: level <= level;
            endcase
        end
    end
endmodule

module motion_seg_seq #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIR_SETUP  = 100
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [31:0]                 cmd_period,
    input  logic [23:0]                 cmd_steps,
    input  logic                        cmd_dir,
    input  logic                        run_en,
    input  logic                        abort,
    input  logic                        step_pulse,
    output logic [31:0]                 sg_period,
    output logic                        sg_dir,
    output logic                        sg_en,
    output logic [23:0]                 steps_left,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        seg_done,
    output logic signed [31:0]          pos
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0] LEVEL_FULL  = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LEVEL_ONE   = LW'(1);
    localparam logic [31:0]   SETTLE_LAST = 32'(DIR_SETUP - 1);
    localparam logic [23:0]   STEPS_ONE   = 24'd1;

    typedef struct packed {
        logic        dir;
        logic [23:0] steps;
        logic [31:0] period;
    } seg_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SETTLE,
        RUN
    } state_t;

    state_t      state;
    state_t      state_nxt;
    seg_t        push_seg;
    seg_t        head;
    logic        seg_push;
    logic        seg_pop;
    logic [31:0] settle_cnt;
    logic [31:0] settle_cnt_nxt;
    logic [31:0] sg_period_nxt;
    logic        sg_dir_nxt;
    logic        sg_en_nxt;
    logic [23:0] steps_left_nxt;
    logic        seg_done_nxt;
    logic        head_seamless;

    assign push_seg  = '{dir: cmd_dir, steps: cmd_steps, period: cmd_period};
    assign cmd_ready = (fifo_level != LEVEL_FULL);
    assign seg_push  = cmd_valid && cmd_ready && !abort;

    motion_seg_fifo #(
        .WIDTH ($bits(seg_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_seg_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (abort),
        .push     (seg_push),
        .push_dat (push_seg),
        .pop      (seg_pop),
        .head_dat (head),
        .level    (fifo_level)
    );

    // next head can take over without dropping sg_en only if it keeps the current direction
    assign head_seamless = run_en && (fifo_level != '0) && (head.steps != '0) && (head.dir == sg_dir);

    // state and every output register; async reset drops sg_en without waiting for a clock edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            sg_period  <= '0;
            sg_dir     <= 1'b0;
            sg_en      <= 1'b0;
            steps_left <= '0;
            seg_done   <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
            sg_period  <= sg_period_nxt;
            sg_dir     <= sg_dir_nxt;
            sg_en      <= sg_en_nxt;
            steps_left <= steps_left_nxt;
            seg_done   <= seg_done_nxt;
        end
    end

    // next-state and next-output decode; abort overrides every state
    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        sg_period_nxt  = sg_period;
        sg_dir_nxt     = sg_dir;
        sg_en_nxt      = sg_en;
        steps_left_nxt = steps_left;
        seg_done_nxt   = 1'b0;
        seg_pop        = 1'b0;
        if (abort) begin
            state_nxt      = IDLE;
            sg_en_nxt      = 1'b0;
            steps_left_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    sg_en_nxt = 1'b0;
                    if (run_en && (fifo_level != '0)) begin
                        state_nxt = LOAD;
                    end
                end
                LOAD: begin
                    sg_en_nxt = 1'b0;
                    if (fifo_level == '0) begin
                        state_nxt = IDLE;
                    end else begin
                        seg_pop = 1'b1;
                        if (head.steps == '0) begin
                            // empty segment: drop it and look at the next one if any
                            state_nxt = (fifo_level > LEVEL_ONE) ? LOAD : IDLE;
                        end else begin
                            sg_period_nxt  = head.period;
                            steps_left_nxt = head.steps;
                            if (head.dir != sg_dir) begin
                                sg_dir_nxt     = head.dir;
                                settle_cnt_nxt = SETTLE_LAST;
                                state_nxt      = SETTLE;
                            end else begin
                                sg_en_nxt = 1'b1;
                                state_nxt = RUN;
                            end
                        end
                    end
                end
                SETTLE: begin
                    sg_en_nxt = 1'b0;
                    if (settle_cnt == '0) begin
                        sg_en_nxt = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        settle_cnt_nxt = settle_cnt - 32'd1;
                    end
                end
                RUN: begin
                    sg_en_nxt = 1'b1;
                    if (step_pulse) begin
                        if (steps_left > STEPS_ONE) begin
                            steps_left_nxt = steps_left - STEPS_ONE;
                        end else begin
                            seg_done_nxt   = 1'b1;
                            steps_left_nxt = '0;
                            if (head_seamless) begin
                                seg_pop        = 1'b1;
                                sg_period_nxt  = head.period;
                                steps_left_nxt = head.steps;
                            end else if (run_en && (fifo_level != '0)) begin
                                sg_en_nxt = 1'b0;
                                state_nxt = LOAD;
                            end else begin
                                sg_en_nxt = 1'b0;
                                state_nxt = IDLE;
                            end
                        end
                    end
                end
                default: begin
                    sg_en_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

`ifdef MOTION_SEG_SEQ_POS_EN
    logic pos_step;

    assign pos_step = (state == RUN) && step_pulse && !abort;

    // position follows every step accepted in RUN, wrapping modulo 2^32; cleared only by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos <= '0;
        end else if (pos_step) begin
            pos <= sg_dir ? (pos + 32'sd1) : (pos - 32'sd1);
        end
    end
`else
    assign pos = '0;
`endif

endmodule
